// File: rtl/comb_gates_bitwise_pkg.sv
// Shared types and the 1-bit gate function for the bitwise logic unit.
// The bit cell and the top module both use these definitions.
package comb_gates_bitwise_pkg;

  localparam int unsigned DefaultWidth = 4;

  // One result bit from each of the four gates, for a single bit position.
  typedef struct packed {
    logic g_and;
    logic g_nand;
    logic g_or;
    logic g_nor;
  } gate_bits_t;

  function automatic gate_bits_t gate_eval(input logic a, input logic b);
    gate_bits_t r;
    r.g_and  = a & b;
    r.g_nand = ~(a & b);
    r.g_or   = a | b;
    r.g_nor  = ~(a | b);
    return r;
  endfunction

endpackage

// File: rtl/comb_gates_bitwise_bit_gates.sv
// Single-bit cell producing AND, NAND, OR and NOR of one operand bit pair.
module comb_gates_bitwise_bit_gates
  import comb_gates_bitwise_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_nand,
  output logic y_or,
  output logic y_nor
);

  gate_bits_t res;

  always_comb begin
    res    = gate_eval(a, b);
    y_and  = res.g_and;
    y_nand = res.g_nand;
    y_or   = res.g_or;
    y_nor  = res.g_nor;
  end

endmodule

// File: rtl/comb_gates_bitwise.sv
// Stateless bitwise AND/NAND/OR/NOR unit; one bit cell per operand bit.
// clk and reset exist only so the block matches its neighbours' interface.
module comb_gates_bitwise
  import comb_gates_bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_nand,
  output logic [WIDTH-1:0] out_or,
  output logic [WIDTH-1:0] out_nor
);

  // Bits never cross positions, so an unknown input bit stays in its own lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    comb_gates_bitwise_bit_gates u_cell (
      .a      (in0[i]),
      .b      (in1[i]),
      .y_and  (out_and[i]),
      .y_nand (out_nand[i]),
      .y_or   (out_or[i]),
      .y_nor  (out_nor[i])
    );
  end

  // Clock and reset are deliberately not used by the datapath.
  logic unused_clk_reset;
  assign unused_clk_reset = ^{clk, reset};

endmodule

// File: tb/tb_comb_gates_bitwise.sv
// Directed and random checks of the bitwise gate unit, including reset
// independence and per-bit isolation of unknown inputs.
module tb_comb_gates_bitwise;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] in0, in1;
  logic [W-1:0] out_and, out_nand, out_or, out_nor;

  int tests;
  int fails;

  comb_gates_bitwise #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .out_and  (out_and),
    .out_nand (out_nand),
    .out_or   (out_or),
    .out_nor  (out_nor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_and;
    logic [W-1:0] e_nand;
    logic [W-1:0] e_or;
    logic [W-1:0] e_nor;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive just after a rising edge, let the next edge approach, sample before it.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic rst);
    @(posedge clk);
    #1;
    in0   = a;
    in1   = b;
    reset = rst;
    #7;
  endtask

  task automatic check_all(input string name, input logic [W-1:0] ea, input logic [W-1:0] ena,
                           input logic [W-1:0] eo, input logic [W-1:0] eno);
    check({name, " and"}, out_and, ea);
    check({name, " nand"}, out_nand, ena);
    check({name, " or"}, out_or, eo);
    check({name, " nor"}, out_nor, eno);
  endtask

  // Golden model written as a per-bit truth table.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output logic [W-1:0] ea,
                       output logic [W-1:0] ena, output logic [W-1:0] eo,
                       output logic [W-1:0] eno);
    for (int i = 0; i < W; i++) begin
      case ({a[i], b[i]})
        2'b00:   begin ea[i] = 1'b0; eo[i] = 1'b0; end
        2'b11:   begin ea[i] = 1'b1; eo[i] = 1'b1; end
        default: begin ea[i] = 1'b0; eo[i] = 1'b1; end
      endcase
      ena[i] = !ea[i];
      eno[i] = !eo[i];
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, ea, ena, eo, eno, snap_and, snap_or;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    in0   = '0;
    in1   = '0;

    vecs.push_back('{"zeros",       1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111});
    vecs.push_back('{"mixed",       1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000});
    vecs.push_back('{"mixed_swap",  1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000});
    vecs.push_back('{"ones",        1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000});
    vecs.push_back('{"truth_a",     1'b1, 4'b1100, 4'b1010, 4'b1000, 4'b0111, 4'b1110, 4'b0001});
    vecs.push_back('{"truth_b",     1'b1, 4'b0011, 4'b0101, 4'b0001, 4'b1110, 4'b0111, 4'b1000});
    vecs.push_back('{"rst_truth_a", 1'b0, 4'b1100, 4'b1010, 4'b1000, 4'b0111, 4'b1110, 4'b0001});
    vecs.push_back('{"rst_ones",    1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000});

    // Outputs follow inputs even while reset is held from time zero.
    #2;
    check_all("reset_time0", 4'b0000, 4'b1111, 4'b0000, 4'b1111);

    foreach (vecs[k]) begin
      apply(vecs[k].a, vecs[k].b, vecs[k].rst);
      check_all(vecs[k].name, vecs[k].e_and, vecs[k].e_nand, vecs[k].e_or, vecs[k].e_nor);
    end

    // Reset asserted mid-operation, then clock toggling: outputs must not move.
    apply(4'b1100, 4'b1010, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check_all("rst_midop", 4'b1000, 4'b0111, 4'b1110, 4'b0001);
    repeat (3) @(posedge clk);
    #2;
    check_all("clk_toggle", 4'b1000, 4'b0111, 4'b1110, 4'b0001);
    reset = 1'b1;
    #1;
    check_all("rst_release", 4'b1000, 4'b0111, 4'b1110, 4'b0001);

    // Unknown on in0[0] with in1[0]=0: AND bit 0 is 0, other lanes unaffected.
    apply(4'b110x, 4'b1010, 1'b1);
    check("xiso and", out_and, 4'b1000);
    check("xiso or_hi", {1'b0, out_or[3:1]}, 4'b0111);
    check("xiso nor_hi", {1'b0, out_nor[3:1]}, 4'b0000);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, ea, ena, eo, eno);
      apply(ra, rb, (n % 5) != 3);
      check_all($sformatf("rand%0d", n), ea, ena, eo, eno);
      snap_and = out_and;
      snap_or  = out_or;
      check($sformatf("rand%0d inv_nand", n), out_nand, ~snap_and);
      check($sformatf("rand%0d inv_nor", n), out_nor, ~snap_or);
      check($sformatf("rand%0d inv_and_or", n), snap_and & ~snap_or, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comb_gates_bitwise.md
Name:
comb_gates_bitwise

Overview:
- Purely combinational bitwise logic unit: computes AND, NAND, OR and NOR of two equal-width vectors, bit by bit.
- Leaf utility block used wherever parallel gate results on a small operand pair are needed.
- Clock and reset ports exist for interface uniformity with the rest of the design; the datapath has no state.

Parameters:
- WIDTH, 4, operand and result width in bits (legal: WIDTH >= 1).

Ports:
- clk  input  1  system clock; no logic is clocked by it in this block.
- reset  input  1  asynchronous, active-low reset; has no effect on outputs.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- out_and  output  WIDTH  in0 & in1, bitwise.
- out_nand  output  WIDTH  ~(in0 & in1), bitwise.
- out_or  output  WIDTH  in0 | in1, bitwise.
- out_nor  output  WIDTH  ~(in0 | in1), bitwise.

Behaviour:
- Zero-latency combinational paths from in0/in1 to all four outputs; no registers, latches or FSM.
- Outputs settle within the same cycle the inputs change. A bench that drives inputs just after a clock edge and checks just before the next edge must see correct values.
- Bit i of each output depends only on bit i of in0 and in1; no cross-bit carry or reduction.
- Invariants for every input pair:
  - out_nand == ~out_and
  - out_nor == ~out_or
  - out_and & ~out_or == 0
- clk and reset are not used functionally:
  - Reset asserted (low), including mid-operation, does not force outputs.
  - Outputs always reflect the current inputs.
  - No reset value is defined beyond the combinational function.
- X/Z on an input bit may propagate only to the same bit position of the outputs.
- No width extension or truncation: all ports are exactly WIDTH bits.

Decomposition:
- No shared package needed; WIDTH is a local parameter.
- One natural sub-module, bit_gates: a 1-bit cell producing and/nand/or/nor, instantiated WIDTH times via generate.
- A flat implementation with continuous assignments is equally acceptable.

Test Plan:
- All zeros: in0=0000, in1=0000 -> and=0000, nand=1111, or=0000, nor=1111.
- Mixed extremes: in0=0000, in1=1111 -> and=0000, nand=1111, or=1111, nor=0000. Swapped operands (1111, 0000) give identical results.
- All ones: in0=1111, in1=1111 -> and=1111, nand=0000, or=1111, nor=0000.
- Full truth table per bit:
  - in0=1100, in1=1010 -> and=1000, nand=0111, or=1110, nor=0001.
  - in0=0011, in1=0101 -> and=0001, nand=1110, or=0111, nor=1000.
- Reset independence: hold reset low while applying 1100/1010 -> outputs identical to the unreset case. Toggle clk -> no output change.
- Random: at least 20 random in0/in1 pairs, each checked against a golden bitwise model and the invariants above, with outputs sampled before the next clk edge.
